crossover_mutation: RTL and testbench

// - Genetic-algorithm breeding stage: takes two parent chromosomes (dad, mom) and produces
//   two children (daughter, son).
// - Uses a per-bit uniform crossover mask, then a per-child XOR mutation mask.
// - Sits between parent selection and the population writeback.
// - The LFSR/random block upstream supplies the masks.

---
 rtl/ga_pkg.sv | 8 +
 rtl/crossover_mutation_core.sv | 20 ++
 rtl/crossover_mutation.sv | 82 ++++++++
 tb/tb_crossover_mutation.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ga_pkg.sv
// ga_pkg: shared chromosome width and type for the genetic-algorithm breeding blocks.
package ga_pkg;

    localparam int GA_WIDTH = 32;

    typedef logic [GA_WIDTH-1:0] chromosome_t;

endpackage

// File: rtl/crossover_mutation_core.sv
// crossover_mutation_core: combinational uniform crossover followed by per-child XOR mutation.
import ga_pkg::*;

module crossover_mutation_core #(
    parameter int Width = GA_WIDTH
) (
    input  logic [Width-1:0] dad,
    input  logic [Width-1:0] mom,
    input  logic [Width-1:0] crossover_mask,
    input  logic [Width-1:0] daughter_mutation_mask,
    input  logic [Width-1:0] son_mutation_mask,
    output logic [Width-1:0] daughter,
    output logic [Width-1:0] son
);

    // Each mask bit routes dad to daughter and mom to son; a clear bit swaps the pair.
    assign daughter = ((crossover_mask & dad) | (~crossover_mask & mom)) ^ daughter_mutation_mask;
    assign son      = ((crossover_mask & mom) | (~crossover_mask & dad)) ^ son_mutation_mask;

endmodule

// File: rtl/crossover_mutation.sv
// crossover_mutation: registered breeding stage, latency 1, or latency 2 when
// CROSSOVER_MUTATION_INREG_EN adds an input register stage.
import ga_pkg::*;

module crossover_mutation #(
    parameter int Width = GA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [Width-1:0] dad,
    input  logic [Width-1:0] mom,
    input  logic [Width-1:0] daughter_mutation_mask,
    input  logic [Width-1:0] son_mutation_mask,
    input  logic [Width-1:0] crossover_mask,
    output logic             out_valid,
    output logic [Width-1:0] daughter,
    output logic [Width-1:0] son
);

    logic             stage_valid;
    logic [Width-1:0] stage_dad;
    logic [Width-1:0] stage_mom;
    logic [Width-1:0] stage_dmm;
    logic [Width-1:0] stage_smm;
    logic [Width-1:0] stage_cm;
    logic [Width-1:0] next_daughter;
    logic [Width-1:0] next_son;

`ifdef CROSSOVER_MUTATION_INREG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_valid <= 1'b0;
            stage_dad   <= '0;
            stage_mom   <= '0;
            stage_dmm   <= '0;
            stage_smm   <= '0;
            stage_cm    <= '0;
        end else begin
            stage_valid <= in_valid;
            stage_dad   <= dad;
            stage_mom   <= mom;
            stage_dmm   <= daughter_mutation_mask;
            stage_smm   <= son_mutation_mask;
            stage_cm    <= crossover_mask;
        end
    end
`else
    assign stage_valid = in_valid;
    assign stage_dad   = dad;
    assign stage_mom   = mom;
    assign stage_dmm   = daughter_mutation_mask;
    assign stage_smm   = son_mutation_mask;
    assign stage_cm    = crossover_mask;
`endif

    crossover_mutation_core #(.Width(Width)) u_core (
        .dad                    (stage_dad),
        .mom                    (stage_mom),
        .crossover_mask         (stage_cm),
        .daughter_mutation_mask (stage_dmm),
        .son_mutation_mask      (stage_smm),
        .daughter               (next_daughter),
        .son                    (next_son)
    );

    // Children only update on a valid sample so the last result stays visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            daughter  <= '0;
            son       <= '0;
        end else begin
            out_valid <= stage_valid;
            if (stage_valid) begin
                daughter <= next_daughter;
                son      <= next_son;
            end
        end
    end

endmodule

// File: tb/tb_crossover_mutation.sv
// tb_crossover_mutation: randomized and directed bench against a queue-based breeding model.
module tb_crossover_mutation;

    localparam int W = 32;
`ifdef CROSSOVER_MUTATION_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic [W-1:0] s;
    } res_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] dad = '0;
    logic [W-1:0] mom = '0;
    logic [W-1:0] dmm = '0;
    logic [W-1:0] smm = '0;
    logic [W-1:0] cm = '0;
    logic         out_valid;
    logic [W-1:0] daughter;
    logic [W-1:0] son;

    int checks = 0;
    int failures = 0;

    res_t         pend[$];
    logic         exp_v = 1'b0;
    logic [W-1:0] exp_d = '0;
    logic [W-1:0] exp_s = '0;

    crossover_mutation #(.Width(W)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .in_valid               (in_valid),
        .dad                    (dad),
        .mom                    (mom),
        .daughter_mutation_mask (dmm),
        .son_mutation_mask      (smm),
        .crossover_mask         (cm),
        .out_valid              (out_valid),
        .daughter               (daughter),
        .son                    (son)
    );

    always #5 clk = ~clk;

    function automatic res_t breed(logic v, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c,
                                   logic [W-1:0] md, logic [W-1:0] ms);
        res_t r;
        r.v = v;
        for (int i = 0; i < W; i++) begin
            r.d[i] = (c[i] ? a[i] : b[i]) ^ md[i];
            r.s[i] = (c[i] ? b[i] : a[i]) ^ ms[i];
        end
        return r;
    endfunction

    task automatic model_reset();
        pend.delete();
        exp_v = 1'b0;
        exp_d = '0;
        exp_s = '0;
    endtask

    // One rising edge; the model learns what that edge samples and what it should emit.
    task automatic step();
        res_t r;
        r = breed(in_valid, dad, mom, cm, dmm, smm);
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            pend.push_back(r);
            exp_v = 1'b0;
            if (pend.size() >= LAT) begin
                r = pend.pop_front();
                exp_v = r.v;
                if (r.v) begin
                    exp_d = r.d;
                    exp_s = r.s;
                end
            end
        end
        #1;
    endtask

    task automatic randomize_inputs();
        dad = $urandom;
        mom = $urandom;
        cm  = $urandom;
        dmm = $urandom;
        smm = $urandom;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || daughter !== '0 || son !== '0) begin
            failures++;
            $display("FAIL reset_async got v=%b d=%h s=%h want v=0 d=0 s=0", out_valid, daughter, son);
        end
        in_valid = 1'b1;
        randomize_inputs();
        repeat (3) step();
        checks++;
        if (out_valid !== 1'b0 || daughter !== '0 || son !== '0) begin
            failures++;
            $display("FAIL reset_held got v=%b d=%h s=%h want v=0 d=0 s=0", out_valid, daughter, son);
        end
        in_valid = 1'b0;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_directed(string name, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c,
                                 logic [W-1:0] md, logic [W-1:0] ms,
                                 logic [W-1:0] want_d, logic [W-1:0] want_s);
        in_valid = 1'b1;
        dad = a;
        mom = b;
        cm  = c;
        dmm = md;
        smm = ms;
        repeat (LAT) step();
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s out_valid got %b want 1", name, out_valid);
        end
        checks++;
        if (daughter !== want_d || daughter !== exp_d) begin
            failures++;
            $display("FAIL %s daughter got %h want %h", name, daughter, want_d);
        end
        checks++;
        if (son !== want_s || son !== exp_s) begin
            failures++;
            $display("FAIL %s son got %h want %h", name, son, want_s);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        in_valid = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            randomize_inputs();
            step();
            checks++;
            if (out_valid !== exp_v || daughter !== exp_d || son !== exp_s) begin
                failures++;
                if (bad++ < 10)
                    $display("FAIL back_to_back[%0d] got v=%b d=%h s=%h want v=%b d=%h s=%h",
                             n, out_valid, daughter, son, exp_v, exp_d, exp_s);
            end
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL back_to_back_valid got %b want 1", out_valid);
        end
    endtask

    task automatic test_gaps();
        int bad = 0;
        for (int n = 0; n < 300; n++) begin
            in_valid = 1'($urandom_range(0, 1));
            randomize_inputs();
            step();
            checks++;
            if (out_valid !== exp_v || daughter !== exp_d || son !== exp_s) begin
                failures++;
                if (bad++ < 10)
                    $display("FAIL gaps[%0d] got v=%b d=%h s=%h want v=%b d=%h s=%h",
                             n, out_valid, daughter, son, exp_v, exp_d, exp_s);
            end
        end
    endtask

    task automatic test_reset_midstream();
        in_valid = 1'b1;
        repeat (5) begin
            randomize_inputs();
            step();
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || daughter !== '0 || son !== '0) begin
            failures++;
            $display("FAIL reset_midstream got v=%b d=%h s=%h want v=0 d=0 s=0", out_valid, daughter, son);
        end
        model_reset();
        in_valid = 1'b0;
        #1 reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            randomize_inputs();
            step();
            checks++;
            if (out_valid !== 1'b0 || daughter !== '0 || son !== '0) begin
                failures++;
                $display("FAIL post_reset_idle[%0d] got v=%b d=%h s=%h want v=0 d=0 s=0",
                         n, out_valid, daughter, son);
            end
        end
        test_directed("post_reset_first", 32'h12345678, 32'h9ABCDEF0, 32'h00000000, '0, '0,
                      32'h9ABCDEF0, 32'h12345678);
    endtask

    initial begin
        test_reset();
        test_directed("half_mask", 32'hFFFFFFFF, 32'h00000000, 32'h0000FFFF, '0, '0,
                      32'h0000FFFF, 32'hFFFF0000);
        test_directed("half_mask_mut", 32'hFFFFFFFF, 32'h00000000, 32'h0000FFFF,
                      32'h00000011, 32'h80000000, 32'h0000FFEE, 32'h7FFF0000);
        test_directed("swap", 32'h12345678, 32'h9ABCDEF0, 32'h00000000, '0, '0,
                      32'h9ABCDEF0, 32'h12345678);
        test_directed("straight_mut", 32'hA5A5A5A5, 32'h3C3C3C3C, 32'hFFFFFFFF,
                      32'h0000000F, 32'hF0000000, 32'hA5A5A5AA, 32'hCC3C3C3C);
        test_directed("invert_all", 32'hDEADBEEF, 32'h01234567, 32'hFFFF0000,
                      32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2152BA98, 32'hFEDC4110);
        test_back_to_back();
        test_gaps();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
